// File: rtl/itu656_pkg.sv
// Shared constants, timing-code helper and 75% colour-bar table for the
// BT.656 encoder.
package itu656_pkg;

   localparam logic [7:0] PREAMBLE_FF = 8'hFF;
   localparam logic [7:0] PREAMBLE_00 = 8'h00;
   localparam logic [7:0] BLANK_C     = 8'h80;
   localparam logic [7:0] BLANK_Y     = 8'h10;

   localparam int NTSC_H_ACTIVE      = 720;
   localparam int NTSC_H_TOTAL_BYTES = 1716;
   localparam int NTSC_V_TOTAL       = 525;
   localparam int NTSC_F2_LINE       = 262;
   localparam int NTSC_F1_ACT_START  = 19;
   localparam int NTSC_F1_ACT_END    = 259;
   localparam int NTSC_F2_ACT_START  = 282;
   localparam int NTSC_F2_ACT_END    = 522;

   // Fourth byte of an EAV/SAV code, including the protection bits.
   function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   endfunction

   // {Y, Cb, Cr} for bars white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [23:0] color_bar(input logic [2:0] bar);
      logic [23:0] ycc;
      case (bar)
         3'd0:    ycc = 24'hB4_80_80;
         3'd1:    ycc = 24'hA2_2C_8E;
         3'd2:    ycc = 24'h83_9C_2C;
         3'd3:    ycc = 24'h70_48_3A;
         3'd4:    ycc = 24'h54_B8_C6;
         3'd5:    ycc = 24'h41_64_D4;
         3'd6:    ycc = 24'h23_D4_72;
         default: ycc = 24'h10_80_80;
      endcase
      return ycc;
   endfunction

endpackage

// File: rtl/itu656_timing.sv
// Byte/line counters and region decode for the BT.656 encoder: EAV/SAV/active
// regions, F and V for the current line, and the pixel request window.
module itu656_timing
   import itu656_pkg::*;
#(
   parameter int H_ACTIVE      = NTSC_H_ACTIVE,
   parameter int H_TOTAL_BYTES = NTSC_H_TOTAL_BYTES,
   parameter int V_TOTAL       = NTSC_V_TOTAL,
   parameter int F2_LINE       = NTSC_F2_LINE,
   parameter int F1_ACT_START  = NTSC_F1_ACT_START,
   parameter int F1_ACT_END    = NTSC_F1_ACT_END,
   parameter int F2_ACT_START  = NTSC_F2_ACT_START,
   parameter int F2_ACT_END    = NTSC_F2_ACT_END
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   output logic [9:0] line_o,
   output logic [1:0] code_idx_o,
   output logic       eav_o,
   output logic       sav_o,
   output logic       act_o,
   output logic       odd_byte_o,
   output logic       act_luma_o,
   output logic       f_o,
   output logic       v_o,
   output logic       req_win_o,
   output logic [9:0] req_x_o
);

   localparam logic [10:0] H_LAST_C    = 11'(H_TOTAL_BYTES - 1);
   localparam logic [10:0] SAV_START_C = 11'(H_TOTAL_BYTES - 2 * H_ACTIVE - 4);
   localparam logic [10:0] ACT_START_C = 11'(H_TOTAL_BYTES - 2 * H_ACTIVE);
   localparam logic [10:0] REQ_START_C = 11'(H_TOTAL_BYTES - 2 * H_ACTIVE - 2);
   localparam logic [10:0] REQ_LAST_C  = 11'(H_TOTAL_BYTES - 4);
   localparam logic [9:0]  V_LAST_C    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  F2_C        = 10'(F2_LINE);
   localparam logic [9:0]  F1S_C       = 10'(F1_ACT_START);
   localparam logic [9:0]  F1E_C       = 10'(F1_ACT_END);
   localparam logic [9:0]  F2S_C       = 10'(F2_ACT_START);
   localparam logic [9:0]  F2E_C       = 10'(F2_ACT_END);

   logic [10:0] hcnt_q, hcnt_d;
   logic [9:0]  line_q, line_d;
   logic [10:0] req_off;

   always_comb begin
      hcnt_d = hcnt_q + 11'd1;
      line_d = line_q;
      if (hcnt_q == H_LAST_C) begin
         hcnt_d = '0;
         line_d = (line_q == V_LAST_C) ? '0 : line_q + 10'd1;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         hcnt_q <= '0;
         line_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         line_q <= line_d;
      end
   end

   assign line_o     = line_q;
   assign eav_o      = (hcnt_q < 11'd4);
   assign sav_o      = (hcnt_q >= SAV_START_C) && (hcnt_q < ACT_START_C);
   assign act_o      = (hcnt_q >= ACT_START_C);
   assign code_idx_o = eav_o ? hcnt_q[1:0] : (hcnt_q[1:0] - SAV_START_C[1:0]);
   // Blanking starts at byte 4, so even byte positions carry the 80 value.
   assign odd_byte_o = hcnt_q[0];
   assign act_luma_o = hcnt_q[0] ^ ACT_START_C[0];

   assign f_o = (line_q >= F2_C);
   assign v_o = (line_q < F1S_C) || ((line_q >= F1E_C) && (line_q < F2S_C)) || (line_q >= F2E_C);

   // Requests lead each chroma byte by two bytes, so the window opens inside SAV.
   assign req_off   = hcnt_q - REQ_START_C;
   assign req_win_o = (hcnt_q >= REQ_START_C) && (hcnt_q <= REQ_LAST_C) && !req_off[0];
   assign req_x_o   = req_off[10:1];

endmodule

// File: rtl/itu_656_encoder.sv
// ITU-R BT.656 byte-stream encoder: codes, blanking, pixel handshake and clamping.
// Define ITU656_COLORBAR_EN to add the iPattern input and internal colour bars.
module itu_656_encoder
   import itu656_pkg::*;
#(
   parameter int H_ACTIVE      = NTSC_H_ACTIVE,
   parameter int H_TOTAL_BYTES = NTSC_H_TOTAL_BYTES,
   parameter int V_TOTAL       = NTSC_V_TOTAL,
   parameter int F2_LINE       = NTSC_F2_LINE,
   parameter int F1_ACT_START  = NTSC_F1_ACT_START,
   parameter int F1_ACT_END    = NTSC_F1_ACT_END,
   parameter int F2_ACT_START  = NTSC_F2_ACT_START,
   parameter int F2_ACT_END    = NTSC_F2_ACT_END
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic [15:0] iYCbCr,
`ifdef ITU656_COLORBAR_EN
   input  logic        iPattern,
`endif
   output logic        oRequest,
   output logic [9:0]  oX,
   output logic [9:0]  oLine,
   output logic [7:0]  oTD_DATA,
   output logic        oF,
   output logic        oV,
   output logic        oH
);

   logic [9:0]  line, req_x;
   logic [1:0]  code_idx;
   logic        eav, sav, act, odd_byte, act_luma, f, v, req_win;

   logic [7:0]  td_q, td_d;
   logic        req_q, req_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  oline_q, oline_d;
   logic        f_q, f_d, v_q, v_d, h_q, h_d;
   logic [15:0] pix_q, pix_d;
   logic [15:0] src_word;

   function automatic logic [7:0] clamp8(input logic [7:0] b);
      logic [7:0] r;
      r = b;
      if (b == 8'h00) r = 8'h01;
      else if (b == 8'hFF) r = 8'hFE;
      return r;
   endfunction

   itu656_timing #(
      .H_ACTIVE      (H_ACTIVE),
      .H_TOTAL_BYTES (H_TOTAL_BYTES),
      .V_TOTAL       (V_TOTAL),
      .F2_LINE       (F2_LINE),
      .F1_ACT_START  (F1_ACT_START),
      .F1_ACT_END    (F1_ACT_END),
      .F2_ACT_START  (F2_ACT_START),
      .F2_ACT_END    (F2_ACT_END)
   ) u_timing (
      .iCLK       (iCLK),
      .iRST_N     (iRST_N),
      .line_o     (line),
      .code_idx_o (code_idx),
      .eav_o      (eav),
      .sav_o      (sav),
      .act_o      (act),
      .odd_byte_o (odd_byte),
      .act_luma_o (act_luma),
      .f_o        (f),
      .v_o        (v),
      .req_win_o  (req_win),
      .req_x_o    (req_x)
   );

`ifdef ITU656_COLORBAR_EN
   localparam logic [9:0] BAR_W_C = 10'(H_ACTIVE / 8);
   logic        pat_q, pat_d;
   logic [2:0]  bar_idx;
   logic [23:0] bar_px;
   assign bar_idx = 3'(x_q / BAR_W_C);
`endif

   always_comb begin
      src_word = pix_q;
`ifdef ITU656_COLORBAR_EN
      bar_px = color_bar(bar_idx);
      // oX keeps tracking pixels while the pattern runs; its LSB picks Cb/Cr.
      if (pat_q) src_word = {bar_px[23:16], x_q[0] ? bar_px[7:0] : bar_px[15:8]};
      pat_d = (line == 10'd0 && eav && code_idx == 2'd0) ? iPattern : pat_q;
`endif
      td_d = odd_byte ? BLANK_Y : BLANK_C;
      if (eav || sav) begin
         case (code_idx)
            2'd0:    td_d = PREAMBLE_FF;
            2'd3:    td_d = xy_code(f, v, eav);
            default: td_d = PREAMBLE_00;
         endcase
      end else if (act && !v) begin
         td_d = clamp8(act_luma ? src_word[15:8] : src_word[7:0]);
      end
      req_d = req_win && !v;
`ifdef ITU656_COLORBAR_EN
      req_d = req_d && !pat_q;
`endif
      x_d     = (req_win && !v) ? req_x : x_q;
      pix_d   = req_q ? iYCbCr : pix_q;
      oline_d = line;
      f_d     = f;
      v_d     = v;
      h_d     = !(sav || act);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         td_q    <= BLANK_Y;
         req_q   <= 1'b0;
         x_q     <= '0;
         oline_q <= '0;
         f_q     <= 1'b0;
         v_q     <= 1'b1;
         h_q     <= 1'b1;
`ifdef ITU656_COLORBAR_EN
         pat_q   <= 1'b0;
`endif
      end else begin
         td_q    <= td_d;
         req_q   <= req_d;
         x_q     <= x_d;
         oline_q <= oline_d;
         f_q     <= f_d;
         v_q     <= v_d;
         h_q     <= h_d;
`ifdef ITU656_COLORBAR_EN
         pat_q   <= pat_d;
`endif
      end
   end

   // Pixel holding register: loaded the clock after a request, used for both bytes.
   always_ff @(posedge iCLK) begin
      pix_q <= pix_d;
   end

   assign oTD_DATA = td_q;
   assign oRequest = req_q;
   assign oX       = x_q;
   assign oLine    = oline_q;
   assign oF       = f_q;
   assign oV       = v_q;
   assign oH       = h_q;

endmodule
